// File: rtl/pipe_flow_ctrl_if.sv
// Handshake bundle between the datapath and the stall/flush controller.
// Master = datapath/fetch side, slave = controller.
interface pipe_flow_ctrl_if #(
    parameter int NREG    = 4,
    parameter int MAX_OUT = 2
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [NREG-1:0]  stall_req;
    logic             flush_req;
    logic             flush_ack;
    logic             inst_req;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic             inst_req_en;
    logic             inst_drop;
    logic [NREG-1:0]  stall;
    logic [NREG-1:0]  refresh;
    logic [CNT_W-1:0] outstanding;
    logic [31:0]      stall_cycles;

    modport master (
        output stall_req, flush_req, inst_req, inst_addr_ok, inst_data_ok,
        input  flush_ack, inst_req_en, inst_drop, stall, refresh, outstanding, stall_cycles
    );

    modport slave (
        input  stall_req, flush_req, inst_req, inst_addr_ok, inst_data_ok,
        output flush_ack, inst_req_en, inst_drop, stall, refresh, outstanding, stall_cycles
    );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Pipeline stall/flush controller: per-register hold/bubble generation, fetch
// tracking with stale-return discard, flush handshake and stall-cycle counter.
module pfc_reg_ctl #(
    parameter int IDX     = 0,
    parameter int EXC_IDX = 1
) (
    input  logic i_chain,
    input  logic i_chain_prev,
    input  logic i_flush_ack,
    input  logic i_fetch_valid,
    output logic o_stall,
    output logic o_refresh
);
    localparam bit YOUNG     = (IDX <= EXC_IDX);
    localparam bit FLUSH_BUB = (IDX <= EXC_IDX + 1);

    logic w_bubble;

    // Flush wins over stall for registers at or younger than the excepting stage.
    assign o_stall   = i_chain & ~(i_flush_ack & YOUNG);
    assign w_bubble  = (IDX == 0) ? (~o_stall & ~i_fetch_valid) : (i_chain_prev & ~i_chain);
    assign o_refresh = (IDX == 0) ? (i_flush_ack | w_bubble)
                                  : ((i_flush_ack & FLUSH_BUB & ~o_stall) | w_bubble);
endmodule

module pipe_flow_ctrl #(
    parameter int NREG    = 4,
    parameter int EXC_IDX = 1,
    parameter int MAX_OUT = 2
) (
    input  logic           clk,
    input  logic           resetn,
    pipe_flow_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [NREG:0]    w_chain;
    logic [NREG-1:0]  w_chain_prev;
    logic [NREG-1:0]  w_stall;
    logic [NREG-1:0]  w_refresh;
    logic             w_flush_ack;
    logic             w_acc;
    logic             w_drop;
    logic             w_fetch_valid;
    logic [CNT_W:0]   w_total;
    logic [CNT_W-1:0] w_sum;
    logic [CNT_W-1:0] w_live_nxt;
    logic [CNT_W-1:0] w_disc_nxt;
    logic [CNT_W-1:0] r_live;
    logic [CNT_W-1:0] r_disc;
    logic [31:0]      r_stall_cycles;

    // chain[i] is set when any stage at or older than i is stalled.
    assign w_chain[NREG] = 1'b0;
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_chain
            assign w_chain[gi] = bus.stall_req[gi] | w_chain[gi+1];
        end
    endgenerate
    assign w_chain_prev = {w_chain[NREG-2:0], 1'b0};

    assign w_flush_ack   = bus.flush_req & ~w_chain[EXC_IDX+1];
    assign w_acc         = bus.inst_req & bus.inst_addr_ok;
    assign w_drop        = bus.inst_data_ok & ((r_disc != '0) | w_flush_ack);
    assign w_fetch_valid = bus.inst_data_ok & ~w_drop;
    assign w_total       = {1'b0, r_live} + {1'b0, r_disc};

    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            pfc_reg_ctl #(.IDX(gi), .EXC_IDX(EXC_IDX)) u_reg (
                .i_chain      (w_chain[gi]),
                .i_chain_prev (w_chain_prev[gi]),
                .i_flush_ack  (w_flush_ack),
                .i_fetch_valid(w_fetch_valid),
                .o_stall      (w_stall[gi]),
                .o_refresh    (w_refresh[gi])
            );
        end
    endgenerate

    // A return with nothing tracked is a protocol error; counters must not wrap.
    always_comb begin
        w_live_nxt = r_live;
        w_disc_nxt = r_disc;
        w_sum      = r_disc + r_live + CNT_W'(w_acc);
        if (w_flush_ack) begin
            w_live_nxt = '0;
            w_disc_nxt = (bus.inst_data_ok && w_sum != '0) ? w_sum - CNT_W'(1) : w_sum;
        end else begin
            if (r_disc != '0 && bus.inst_data_ok)
                w_disc_nxt = r_disc - CNT_W'(1);
            if (w_acc && !(w_fetch_valid && r_live != '0))
                w_live_nxt = r_live + CNT_W'(1);
            else if (!w_acc && w_fetch_valid && r_live != '0)
                w_live_nxt = r_live - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_live         <= '0;
            r_disc         <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_live <= w_live_nxt;
            r_disc <= w_disc_nxt;
            if (w_stall[0] && r_stall_cycles != 32'hFFFF_FFFF)
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.flush_ack    = w_flush_ack;
    assign bus.inst_drop    = w_drop;
    assign bus.inst_req_en  = (w_total < (CNT_W+1)'(MAX_OUT)) && (r_disc == '0);
    assign bus.stall        = w_stall;
    assign bus.refresh      = w_refresh;
    assign bus.outstanding  = r_live;
    assign bus.stall_cycles = r_stall_cycles;
endmodule
